pe_context_store: RTL and testbench
===================================

PE_CONTEXT_STORE -- requirements
Module: pe_context_store

Interface
REQ-001 The block SHALL have parameter DATA_W, default 121: context word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 64: number of context entries, a power of two, 2..1024.
REQ-003 The block SHALL have parameter AW, default $clog2(DEPTH): address width.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock; all state SHALL update on the rising edge.
REQ-005 The block SHALL have port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit: 0 = load phase, 1 = run phase.
REQ-007 The block SHALL have port clear, input, 1 bit: synchronous restart of the load pointer.
REQ-008 The block SHALL have port load_valid, input, 1 bit: load word offered.
REQ-009 The block SHALL have port load_data, input, DATA_W bits: load word.
REQ-010 The block SHALL have port load_ready, output, 1 bit: the store accepts a word this cycle.
REQ-011 The block SHALL have port CP, input, AW bits: external context pointer.
REQ-012 The block SHALL have port run_en, input, 1 bit: read enable in the run phase.
REQ-013 The block SHALL have port seq_mode, input, 1 bit: 1 = internal sequencer addresses, 0 = CP addresses.
REQ-014 The block SHALL have port out_data, output, DATA_W bits: registered context word.
REQ-015 The block SHALL have port out_valid, output, 1 bit: out_data holds a valid read.
REQ-016 The block SHALL have port err_oob, output, 1 bit: one-cycle pulse on an out-of-range read.
REQ-017 The block SHALL have port count, output, AW+1 bits: number of entries loaded.
REQ-018 The block SHALL have port full, output, 1 bit: count == DEPTH.
REQ-019 The block SHALL have port seq_ptr, output, AW bits: current sequencer address.

Function
REQ-020 load_ready SHALL equal (start==0) && !full && !clear, combinationally.
REQ-021 When load_valid && load_ready, the block SHALL write load_data at index count[AW-1:0] and increment count by 1, so entries are written in arrival order from index 0.
REQ-022 When clear==1, the block SHALL set count to 0 on the next edge and SHALL NOT perform a write, even if load_valid==1.
REQ-023 Memory contents SHALL be retained across clear and across phase changes.
REQ-024 When full, the block SHALL drop load_valid with no write and no count change; count SHALL NOT wrap.
REQ-025 While start==1, the block SHALL ignore load_valid.
REQ-026 In the run phase, the read address A SHALL be seq_ptr when seq_mode==1 and the sequencer is compiled in, and CP otherwise.
REQ-027 In the run phase with run_en==1 and A < count, the block SHALL register mem[A] into out_data and set out_valid=1 on the next edge, giving a latency of 1 cycle.
REQ-028 In the run phase with run_en==1 and A >= count, the block SHALL set out_data to 0, out_valid to 0 and err_oob to 1 for one cycle; count==0 SHALL make every read out-of-range.
REQ-029 When run_en==0 or start==0, the block SHALL hold out_data, clear out_valid and clear err_oob.
REQ-030 The sequencer SHALL set seq_ptr to 0 on the cycle after any start 0->1 transition.
REQ-031 Otherwise, with start==1, run_en==1 and seq_mode==1, seq_ptr SHALL increment each cycle and wrap to 0 after count-1.
REQ-032 A start 0->1 transition and a read in the same cycle SHALL read address 0 when seq_mode==1.

Reset
REQ-033 On RST_N low, the block SHALL immediately set count, seq_ptr, out_data, out_valid and err_oob to 0, regardless of CLK.
REQ-034 Memory contents SHALL NOT be reset; after reset, all reads SHALL be out-of-range until reloaded.
REQ-035 When reset is asserted mid-load or mid-run, the block SHALL abort the operation with no partial write.
REQ-036 The first edge after RST_N rises SHALL be a normal operating edge.

Configuration
REQ-037 The macro PE_CTX_AUTOSEQ_EN SHALL control the internal sequencer.
REQ-038 When PE_CTX_AUTOSEQ_EN is defined, the sequencer SHALL be compiled in and SHALL behave per REQ-026 and REQ-030 to REQ-032.
REQ-039 When PE_CTX_AUTOSEQ_EN is undefined, the block SHALL keep all ports, ignore seq_mode, address by CP only, and tie seq_ptr to 0.

Verification
REQ-040 The bench SHALL reset, load 5 words 0x10..0x14 with start=0, then check count==5, full==0, and that CP=3 with run_en gives out_data==0x13 one cycle later with out_valid=1.
REQ-041 The bench SHALL load DEPTH words, then check full==1 and load_ready==0, offer one more word, and check no write occurs and count stays DEPTH.
REQ-042 The bench SHALL load 3 words, set start=1 and CP=3, and check err_oob pulses one cycle, out_valid==0 and out_data==0.
REQ-043 The bench SHALL drive clear and load_valid in the same cycle after 4 loads, and check count==0 with entry 0 unchanged; the next load SHALL write index 0.
REQ-044 With PE_CTX_AUTOSEQ_EN defined, the bench SHALL load 3 words A,B,C, set seq_mode=1 and start=1 with run_en held, and check out_data sequence A,B,C,A,B and seq_ptr wrapping 2->0.
REQ-045 The bench SHALL assert RST_N low between clock edges mid-run, and check all outputs go to 0 at once and that a read after release flags err_oob.

Source files
------------

// File: rtl/pe_context_store.sv
// pe_context_store: loadable context memory for a processing element.
//
// Load phase (start=0): words offered on load_valid/load_data are written in
// arrival order from index 0; count tracks how many entries hold valid data.
// Run phase (start=1): with run_en, the entry at address A is registered into
// out_data one cycle later. A is CP, or the internal sequencer pointer when
// seq_mode=1 and the sequencer is built. Reads at or beyond count clear
// out_valid and pulse err_oob.
//
// Build option: define PE_CTX_AUTOSEQ_EN to include the internal sequencer.
// Without it, seq_mode is ignored, all reads use CP and seq_ptr reads as 0.
//
// Ports:
//   CLK, RST_N          clock, asynchronous active-low reset
//   start               0 = load phase, 1 = run phase
//   clear               synchronous restart of the load pointer (count -> 0)
//   load_valid/data     load word handshake, load_ready = accept this cycle
//   CP                  external context pointer
//   run_en              read enable in the run phase
//   seq_mode            1 = sequencer addresses, 0 = CP addresses
//   out_data/out_valid  registered read result
//   err_oob             one-cycle flag for an out-of-range read
//   count, full         entries loaded, count == DEPTH
//   seq_ptr             current sequencer address
module pe_context_store #(
  parameter int unsigned DATA_W = 121,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  input  logic              clear,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  input  logic [AW-1:0]     CP,
  input  logic              run_en,
  input  logic              seq_mode,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              err_oob,
  output logic [AW:0]       count,
  output logic              full,
  output logic [AW-1:0]     seq_ptr
);

  localparam logic [AW:0] DepthCnt = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_count;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_err_oob;

  logic              w_full;
  logic              w_we;
  logic              w_rd;
  logic [AW-1:0]     w_addr;
  logic              w_in_range;

  assign w_full     = (r_count == DepthCnt);
  assign load_ready = !start && !w_full && !clear;
  assign w_we       = load_valid && load_ready;
  assign w_rd       = start && run_en;

`ifdef PE_CTX_AUTOSEQ_EN
  logic [AW-1:0] r_seq_ptr;
  logic [AW:0]   w_seq_inc;
  logic [AW-1:0] w_seq_next;

  assign w_seq_inc  = {1'b0, r_seq_ptr} + (AW+1)'(1);
  // Wrap after count-1; with count==0 the pointer stays parked at 0.
  assign w_seq_next = (w_seq_inc >= r_count) ? '0 : w_seq_inc[AW-1:0];
  assign w_addr     = seq_mode ? r_seq_ptr : CP;
  assign seq_ptr    = r_seq_ptr;

  // Parked at 0 throughout the load phase, so the cycle that raises start
  // already addresses entry 0 and the pointer is 0 on entry to the run phase.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_seq_ptr <= '0;
    end else if (!start) begin
      r_seq_ptr <= '0;
    end else if (run_en && seq_mode) begin
      r_seq_ptr <= w_seq_next;
    end
  end
`else
  logic w_unused_seq_mode;

  assign w_unused_seq_mode = seq_mode;
  assign w_addr            = CP;
  assign seq_ptr           = '0;
`endif

  assign w_in_range = ({1'b0, w_addr} < r_count);

  // Contents survive reset; the reset branch only blocks writes while RST_N
  // is low so an interrupted load leaves no partial entry behind.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
    end else if (w_we) begin
      r_mem[r_count[AW-1:0]] <= load_data;
    end
  end

  // clear wins over a simultaneous load; load_ready is already low then.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (w_we) begin
      r_count <= r_count + (AW+1)'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_err_oob   <= 1'b0;
    end else if (w_rd) begin
      if (w_in_range) begin
        r_out_data  <= r_mem[w_addr];
        r_out_valid <= 1'b1;
        r_err_oob   <= 1'b0;
      end else begin
        r_out_data  <= '0;
        r_out_valid <= 1'b0;
        r_err_oob   <= 1'b1;
      end
    end else begin
      r_out_valid <= 1'b0;
      r_err_oob   <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign err_oob   = r_err_oob;
  assign count     = r_count;
  assign full      = w_full;

endmodule

// File: tb/tb_pe_context_store.sv
module tb_pe_context_store;

  localparam int unsigned DATA_W = 121;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned AW     = 3;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic              start;
  logic              clear;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic [AW-1:0]     CP;
  logic              run_en;
  logic              seq_mode;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              err_oob;
  logic [AW:0]       count;
  logic              full;
  logic [AW-1:0]     seq_ptr;

  int checks   = 0;
  int failures = 0;

  pe_context_store #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .start      (start),
    .clear      (clear),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .CP         (CP),
    .run_en     (run_en),
    .seq_mode   (seq_mode),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .err_oob    (err_oob),
    .count      (count),
    .full       (full),
    .seq_ptr    (seq_ptr)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit before sampling.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_word(input logic [DATA_W-1:0] d);
    load_valid = 1'b1;
    load_data  = d;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N      = 1'b0;
    start      = 1'b0;
    clear      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    CP         = '0;
    run_en     = 1'b0;
    seq_mode   = 1'b0;

    // Reset state
    #3;
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err_oob", err_oob, 0);
    chk("rst_seq_ptr", seq_ptr, 0);
    chk("rst_load_ready", load_ready, 1);
    #9;
    RST_N = 1'b1;
    tick();

    // Load five words, read back via CP
    for (int i = 0; i < 5; i++) load_word(DATA_W'(8'h10 + i));
    chk("ld5_count", count, 5);
    chk("ld5_full", full, 0);
    start      = 1'b1;
    CP         = 3'd3;
    run_en     = 1'b1;
    load_valid = 1'b1;
    load_data  = DATA_W'(8'hEE);
    #1;
    chk("run_load_ready", load_ready, 0);
    tick();
    load_valid = 1'b0;
    chk("rd3_data", out_data, 'h13);
    chk("rd3_valid", out_valid, 1);
    chk("rd3_err", err_oob, 0);
    chk("run_ignores_load", count, 5);
    CP = 3'd4;
    tick();
    chk("rd4_data", out_data, 'h14);
    CP = 3'd5;
    tick();
    chk("rd5_oob_err", err_oob, 1);
    chk("rd5_oob_valid", out_valid, 0);
    chk("rd5_oob_data", out_data, 0);
    CP = 3'd0;
    tick();
    chk("rd0_data", out_data, 'h10);
    chk("rd0_err", err_oob, 0);
    run_en = 1'b0;
    tick();
    chk("hold_data", out_data, 'h10);
    chk("hold_valid", out_valid, 0);
    start  = 1'b0;
    run_en = 1'b1;
    CP     = 3'd1;
    tick();
    chk("load_phase_no_read_data", out_data, 'h10);
    chk("load_phase_no_read_valid", out_valid, 0);
    run_en = 1'b0;

    // Clear together with a load offer
    do_clear();
    chk("clr_count", count, 0);
    for (int i = 0; i < 4; i++) load_word(DATA_W'(8'h20 + i));
    chk("ld4_count", count, 4);
    clear      = 1'b1;
    load_valid = 1'b1;
    load_data  = DATA_W'(8'h99);
    #1;
    chk("clr_load_ready", load_ready, 0);
    tick();
    clear      = 1'b0;
    load_valid = 1'b0;
    chk("clr_ld_count", count, 0);
    load_word(DATA_W'(8'h30));
    chk("after_clr_count", count, 1);
    start  = 1'b1;
    run_en = 1'b1;
    CP     = 3'd0;
    tick();
    chk("after_clr_idx0", out_data, 'h30);
    CP = 3'd1;
    tick();
    chk("after_clr_idx1_oob", err_oob, 1);
    run_en = 1'b0;
    start  = 1'b0;

    // Fill to DEPTH, then offer one more
    do_clear();
    for (int i = 0; i < DEPTH; i++) load_word(DATA_W'(8'h40 + i));
    chk("full_count", count, DEPTH);
    chk("full_flag", full, 1);
    chk("full_load_ready", load_ready, 0);
    load_word(DATA_W'(8'hAA));
    chk("full_no_wrap", count, DEPTH);
    start  = 1'b1;
    run_en = 1'b1;
    CP     = 3'd0;
    tick();
    chk("full_idx0_kept", out_data, 'h40);
    CP = 3'd7;
    tick();
    chk("full_idx7", out_data, 'h47);
    run_en = 1'b0;
    start  = 1'b0;

    // Out-of-range pulse after three loads
    do_clear();
    for (int i = 0; i < 3; i++) load_word(DATA_W'(8'h50 + i));
    start  = 1'b1;
    run_en = 1'b1;
    CP     = 3'd3;
    tick();
    chk("oob_err", err_oob, 1);
    chk("oob_valid", out_valid, 0);
    chk("oob_data", out_data, 0);
    run_en = 1'b0;
    tick();
    chk("oob_pulse_end", err_oob, 0);
    run_en = 1'b1;
    CP     = 3'd2;
    tick();
    chk("oob_then_rd2", out_data, 'h52);
    run_en = 1'b0;
    start  = 1'b0;
    tick();

    // Sequencer walk over A,B,C
    do_clear();
    for (int i = 0; i < 3; i++) load_word(DATA_W'(8'h61 + i));
    chk("seq_ptr_load_phase", seq_ptr, 0);
    seq_mode = 1'b1;
    run_en   = 1'b1;
    CP       = 3'd2;
    start    = 1'b1;
`ifdef PE_CTX_AUTOSEQ_EN
    begin
      logic [7:0] exp_d [5];
      logic [2:0] exp_p [5];
      exp_d = '{8'h61, 8'h62, 8'h63, 8'h61, 8'h62};
      exp_p = '{3'd1, 3'd2, 3'd0, 3'd1, 3'd2};
      for (int i = 0; i < 5; i++) begin
        tick();
        chk($sformatf("seq_data_%0d", i), out_data, 128'(exp_d[i]));
        chk($sformatf("seq_ptr_%0d", i), seq_ptr, 128'(exp_p[i]));
      end
    end
`else
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("noseq_cp_data_%0d", i), out_data, 'h63);
      chk($sformatf("noseq_ptr_%0d", i), seq_ptr, 0);
    end
`endif

    // Asynchronous reset mid-run
    chk("pre_rst_valid", out_valid, 1);
    #2;
    RST_N = 1'b0;
    #1;
    chk("arst_out_data", out_data, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_err_oob", err_oob, 0);
    chk("arst_count", count, 0);
    chk("arst_full", full, 0);
    chk("arst_seq_ptr", seq_ptr, 0);
    #1;
    RST_N    = 1'b1;
    seq_mode = 1'b0;
    CP       = 3'd0;
    tick();
    chk("post_rst_oob_err", err_oob, 1);
    chk("post_rst_oob_valid", out_valid, 0);
    run_en = 1'b0;
    start  = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
